// File: rtl/midi_msg_parser.sv
// midi_msg_parser
//   Decodes a MIDI byte stream into note-on / note-off messages and holds the
//   most recent one in a single-entry output register with a valid/ready
//   handshake. Running status, real-time bytes and system messages are handled
//   in the parser; only note messages (status types 0x8 and 0x9) reach the
//   outputs.
//
// Ports
//   CLK        in   system clock, all state on posedge
//   RESET      in   synchronous active-low reset
//   BYTE_IN    in   [7:0] received byte
//   BYTE_VALID in   one-cycle strobe qualifying BYTE_IN
//   MSG_READY  in   consumer accepts the held message
//   CHAN_SEL   in   [3:0] channel filter (only with MIDI_MSG_PARSER_CHAN_FILTER_EN)
//   MSG_VALID  out  a decoded note message is held
//   NOTE_ON    out  1 = note-on, 0 = note-off (incl. note-on with velocity 0)
//   CHANNEL    out  [3:0] channel of the message
//   NOTE       out  [6:0] note number
//   VELOCITY   out  [6:0] velocity
//   OVERRUN    out  sticky: a completed note message was dropped
//
// Build option
//   MIDI_MSG_PARSER_CHAN_FILTER_EN: adds CHAN_SEL; note messages on other
//   channels are parsed but neither emitted nor counted as overruns.

module midi_msg_parser (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BYTE_IN,
  input  logic       BYTE_VALID,
  input  logic       MSG_READY,
`ifdef MIDI_MSG_PARSER_CHAN_FILTER_EN
  input  logic [3:0] CHAN_SEL,
`endif
  output logic       MSG_VALID,
  output logic       NOTE_ON,
  output logic [3:0] CHANNEL,
  output logic [6:0] NOTE,
  output logic [6:0] VELOCITY,
  output logic       OVERRUN
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StWaitD1 = 2'd1;
  localparam logic [1:0] StWaitD2 = 2'd2;
  localparam logic [1:0] StSkip   = 2'd3;

  // Parser state
  logic [1:0] state_q, state_d;
  logic       rs_valid_q, rs_valid_d;
  logic [3:0] rs_type_q, rs_type_d;
  logic [3:0] rs_chan_q, rs_chan_d;
  logic [6:0] data1_q, data1_d;

  // Output register
  logic       msg_valid_q, msg_valid_d;
  logic       note_on_q, note_on_d;
  logic [3:0] channel_q, channel_d;
  logic [6:0] note_q, note_d;
  logic [6:0] velocity_q, velocity_d;
  logic       overrun_q, overrun_d;

  logic is_rt;
  logic one_byte;
  logic complete;
  logic is_note;
  logic chan_ok;
  logic emit;
  logic handshake;

  assign is_rt    = (BYTE_IN[7:3] == 5'b11111);
  assign one_byte = (rs_type_q == 4'hC) || (rs_type_q == 4'hD);
  assign is_note  = (rs_type_q == 4'h8) || (rs_type_q == 4'h9);

`ifdef MIDI_MSG_PARSER_CHAN_FILTER_EN
  assign chan_ok = (rs_chan_q == CHAN_SEL);
`else
  assign chan_ok = 1'b1;
`endif

  // Byte classification and message assembly
  always_comb begin
    state_d    = state_q;
    rs_valid_d = rs_valid_q;
    rs_type_d  = rs_type_q;
    rs_chan_d  = rs_chan_q;
    data1_d    = data1_q;
    complete   = 1'b0;

    if (BYTE_VALID && !is_rt) begin
      if (BYTE_IN[7]) begin
        // Any status byte aborts a partial message
        if (BYTE_IN[7:4] != 4'hF) begin
          rs_valid_d = 1'b1;
          rs_type_d  = BYTE_IN[7:4];
          rs_chan_d  = BYTE_IN[3:0];
          state_d    = StWaitD1;
        end else begin
          rs_valid_d = 1'b0;
          rs_type_d  = 4'h0;
          rs_chan_d  = 4'h0;
          state_d    = StSkip;
        end
      end else begin
        case (state_q)
          // IDLE with running status behaves exactly like WAIT_D1
          StIdle, StWaitD1: begin
            if (rs_valid_q) begin
              if (one_byte) begin
                complete = 1'b1;
                state_d  = StIdle;
              end else begin
                data1_d = BYTE_IN[6:0];
                state_d = StWaitD2;
              end
            end
          end
          StWaitD2: begin
            complete = 1'b1;
            state_d  = StIdle;
          end
          default: ; // SKIP: data discarded
        endcase
      end
    end
  end

  // Only two-byte note messages reach the outputs; in that case the
  // completing byte is always data byte 2.
  assign emit      = complete && is_note && chan_ok;
  assign handshake = msg_valid_q && MSG_READY;

  always_comb begin
    msg_valid_d = msg_valid_q;
    note_on_d   = note_on_q;
    channel_d   = channel_q;
    note_d      = note_q;
    velocity_d  = velocity_q;
    overrun_d   = overrun_q;

    if (emit) begin
      if (!msg_valid_q || MSG_READY) begin
        msg_valid_d = 1'b1;
        note_on_d   = (rs_type_q == 4'h9) && (BYTE_IN[6:0] != 7'd0);
        channel_d   = rs_chan_q;
        note_d      = data1_q;
        velocity_d  = BYTE_IN[6:0];
      end else begin
        overrun_d = 1'b1;
      end
    end else if (handshake) begin
      msg_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= StIdle;
      rs_valid_q  <= 1'b0;
      rs_type_q   <= 4'h0;
      rs_chan_q   <= 4'h0;
      data1_q     <= 7'd0;
      msg_valid_q <= 1'b0;
      note_on_q   <= 1'b0;
      channel_q   <= 4'h0;
      note_q      <= 7'd0;
      velocity_q  <= 7'd0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rs_valid_q  <= rs_valid_d;
      rs_type_q   <= rs_type_d;
      rs_chan_q   <= rs_chan_d;
      data1_q     <= data1_d;
      msg_valid_q <= msg_valid_d;
      note_on_q   <= note_on_d;
      channel_q   <= channel_d;
      note_q      <= note_d;
      velocity_q  <= velocity_d;
      overrun_q   <= overrun_d;
    end
  end

  assign MSG_VALID = msg_valid_q;
  assign NOTE_ON   = note_on_q;
  assign CHANNEL   = channel_q;
  assign NOTE      = note_q;
  assign VELOCITY  = velocity_q;
  assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Testbench for midi_msg_parser: directed sequences followed by randomized
// byte streams. A reference model tracks running status and collected data
// bytes and pushes expected note messages into a scoreboard queue; a monitor
// on the falling edge compares the DUT's held message against the queue.
module tb_midi_msg_parser;

  logic       clk;
  logic       rst_n;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       msg_ready;
  logic       msg_valid;
  logic       note_on;
  logic [3:0] channel;
  logic [6:0] note;
  logic [6:0] velocity;
  logic       overrun;
`ifdef MIDI_MSG_PARSER_CHAN_FILTER_EN
  logic [3:0] chan_sel;
`endif

  midi_msg_parser dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .BYTE_IN   (byte_in),
    .BYTE_VALID(byte_valid),
    .MSG_READY (msg_ready),
`ifdef MIDI_MSG_PARSER_CHAN_FILTER_EN
    .CHAN_SEL  (chan_sel),
`endif
    .MSG_VALID (msg_valid),
    .NOTE_ON   (note_on),
    .CHANNEL   (channel),
    .NOTE      (note),
    .VELOCITY  (velocity),
    .OVERRUN   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       on;
    logic [3:0] ch;
    logic [6:0] nt;
    logic [6:0] vel;
  } msg_t;

  msg_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int   rs = -1;          // running status byte, -1 when none
  int   dq[$];            // data bytes collected for the current message
  bit   exp_valid = 0;
  bit   exp_overrun = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit chan_pass(input int ch);
`ifdef MIDI_MSG_PARSER_CHAN_FILTER_EN
    return ch == int'(chan_sel);
`else
    return ch >= 0;
`endif
  endfunction

  // Applies the effect of one clock edge given the inputs of that cycle
  task automatic model_step(input bit rst, input bit bv, input int b, input bit rdy);
    bit   done = 0;
    int   typ;
    int   need;
    msg_t m;
    if (!rst) begin
      rs = -1;
      dq.delete();
      exp_valid = 0;
      exp_overrun = 0;
      sb.delete();
      return;
    end
    if (bv && b < 'hF8) begin
      if (b >= 'h80) begin
        rs = (b < 'hF0) ? b : -1;
        dq.delete();
      end else if (rs >= 0) begin
        dq.push_back(b);
        typ  = rs / 16;
        need = (typ == 'hC || typ == 'hD) ? 1 : 2;
        if (dq.size() == need) begin
          done = 1;
          if ((typ == 8 || typ == 9) && chan_pass(rs % 16)) begin
            m.on  = (typ == 9) && (dq[1] != 0);
            m.ch  = 4'(rs % 16);
            m.nt  = 7'(dq[0]);
            m.vel = 7'(dq[1]);
          end else begin
            done = 0;
          end
          dq.delete();
        end
      end
    end
    if (done) begin
      if (!exp_valid || rdy) begin
        exp_valid = 1;
        sb.push_back(m);
      end else begin
        exp_overrun = 1;
      end
    end else if (exp_valid && rdy) begin
      exp_valid = 0;
    end
  endtask

  task automatic cyc(input bit rst, input bit bv, input logic [7:0] b, input bit rdy);
    rst_n      = rst;
    byte_valid = bv;
    byte_in    = b;
    msg_ready  = rdy;
    @(posedge clk);
    model_step(rst, bv, int'(b), rdy);
    #1;
    rst_n      = 1'b1;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic send(input logic [7:0] b, input bit rdy);
    cyc(1'b1, 1'b1, b, rdy);
    cyc(1'b1, 1'b0, 8'h00, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00, rdy);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " valid"}, int'(msg_valid), 0);
    chk({tag, " note_on"}, int'(note_on), 0);
    chk({tag, " channel"}, int'(channel), 0);
    chk({tag, " note"}, int'(note), 0);
    chk({tag, " velocity"}, int'(velocity), 0);
    chk({tag, " overrun"}, int'(overrun), 0);
  endtask

  // Monitor: compare held message with the scoreboard head every cycle
  always @(negedge clk) begin
    if (rst_n) begin
      chk("msg_valid", int'(msg_valid), int'(exp_valid));
      chk("overrun", int'(overrun), int'(exp_overrun));
      if (msg_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected msg", 1, 0);
        end else begin
          chk("note_on", int'(note_on), int'(sb[0].on));
          chk("channel", int'(channel), int'(sb[0].ch));
          chk("note", int'(note), int'(sb[0].nt));
          chk("velocity", int'(velocity), int'(sb[0].vel));
          if (msg_ready) void'(sb.pop_front());
        end
      end
    end
  end

  logic [7:0] rb;
  int         r;

  initial begin
`ifdef MIDI_MSG_PARSER_CHAN_FILTER_EN
    chan_sel = 4'd2;
`endif
    rst_n = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; msg_ready = 1'b0;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check_zero("reset");

    // Basic note-on, no gaps
    cyc(1'b1, 1'b1, 8'h93, 1'b1);
    cyc(1'b1, 1'b1, 8'h3C, 1'b1);
    cyc(1'b1, 1'b1, 8'h64, 1'b1);
    idle(3, 1'b1);

    // Running status, velocity 0 note-on becomes note-off
    send(8'h90, 1'b1); send(8'h40, 1'b1); send(8'h50, 1'b1);
    send(8'h40, 1'b1); send(8'h00, 1'b1);
    idle(2, 1'b1);

    // Real-time byte inside a message; system status suppresses data
    send(8'h90, 1'b1); send(8'h3C, 1'b1); send(8'hF8, 1'b1); send(8'h64, 1'b1);
    send(8'hF0, 1'b1); send(8'h3C, 1'b1); send(8'h64, 1'b1);
    idle(2, 1'b1);

    // Status byte mid-message aborts it; non-note types are silent
    send(8'h95, 1'b1); send(8'h11, 1'b1); send(8'h86, 1'b1);
    send(8'h22, 1'b1); send(8'h33, 1'b1);
    send(8'hC4, 1'b1); send(8'h05, 1'b1); send(8'h06, 1'b1);
    send(8'hB0, 1'b1); send(8'h07, 1'b1); send(8'h08, 1'b1);
    idle(2, 1'b1);

    // Hold and overrun, then handshake
    send(8'h80, 1'b0); send(8'h30, 1'b0); send(8'h00, 1'b0);
    send(8'h80, 1'b0); send(8'h31, 1'b0); send(8'h00, 1'b0);
    idle(3, 1'b0);
    idle(2, 1'b1);

    // Load in the same cycle as a handshake
    send(8'h91, 1'b0); send(8'h10, 1'b0);
    cyc(1'b1, 1'b1, 8'h20, 1'b0);
    cyc(1'b1, 1'b1, 8'h11, 1'b0);
    cyc(1'b1, 1'b1, 8'h21, 1'b1);
    idle(3, 1'b1);

    // Reset mid-message discards the partial message and clears overrun
    send(8'h90, 1'b1); send(8'h3C, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    send(8'h64, 1'b1);
    idle(2, 1'b1);
    check_zero("after reset");

    // Channel filter (in the default build both messages are emitted)
    send(8'h91, 1'b1); send(8'h3C, 1'b1); send(8'h64, 1'b1);
    send(8'h92, 1'b1); send(8'h3C, 1'b1); send(8'h64, 1'b1);
    idle(2, 1'b1);

    // Randomized stream
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 18)      rb = {3'b100, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3))};
      else if (r < 24) rb = {4'($urandom_range(10, 14)), 4'($urandom_range(0, 3))};
      else if (r < 28) rb = {5'b11110, 3'($urandom_range(0, 7))};
      else if (r < 33) rb = {5'b11111, 3'($urandom_range(0, 7))};
      else if (r < 40) rb = 8'h00;
      else             rb = {1'b0, 7'($urandom)};
      if (r >= 33 && r < 36) cyc(1'b1, 1'b0, 8'h00, $urandom_range(0, 3) != 0);
      else if ($urandom_range(0, 599) == 0) cyc(1'b0, 1'b0, 8'h00, 1'b1);
      else cyc(1'b1, 1'b1, rb, $urandom_range(0, 3) != 0);
    end

    idle(4, 1'b1);
    chk("scoreboard drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
